// File: rtl/gnn_result_drain.sv
// ============================================================================
// Module      : gnn_result_drain
// Description : Consumer end of the GNN accelerator output interface. Captures
//               eight signed class scores when all per-score ready flags are
//               high, buffers whole frames in a small frame FIFO and streams
//               them out one word per beat over a valid/ready handshake.
//               Optional macro GNN_DRAIN_SUM_EN appends a ninth beat holding
//               the wrap-around sum of the frame's eight scores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnn_result_drain #(
    parameter int DW    = 21,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] out0_node0,
    input  logic signed [DW-1:0] out1_node0,
    input  logic signed [DW-1:0] out0_node1,
    input  logic signed [DW-1:0] out1_node1,
    input  logic signed [DW-1:0] out0_node2,
    input  logic signed [DW-1:0] out1_node2,
    input  logic signed [DW-1:0] out0_node3,
    input  logic signed [DW-1:0] out1_node3,
    input  logic                 out10_ready_node0,
    input  logic                 out11_ready_node0,
    input  logic                 out10_ready_node1,
    input  logic                 out11_ready_node1,
    input  logic                 out10_ready_node2,
    input  logic                 out11_ready_node2,
    input  logic                 out10_ready_node3,
    input  logic                 out11_ready_node3,
    output logic signed [DW-1:0] dout,
    output logic [3:0]           dout_idx,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    input  logic                 err_clr,
    output logic                 overrun,
    output logic                 flag_err,
    output logic [CNTW-1:0]      drop_cnt
);

`ifdef GNN_DRAIN_SUM_EN
    localparam int NB = 9;
    localparam int BW = 4;
`else
    localparam int NB = 8;
    localparam int BW = 3;
`endif
    // DEPTH is restricted to 2 or 4, so pointers wrap naturally
    localparam int              PW        = (DEPTH > 2) ? 2 : 1;
    localparam int              CW        = PW + 1;
    localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
    localparam logic [3:0]      LAST_BEAT = 4'(NB - 1);
    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_STREAM  = 1'b1;

    logic [7:0]      w_flags;
    logic            w_cap;
    logic            w_partial;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_wr_en;
    logic            w_drop;
    logic [DW-1:0]   w_frame [NB];

    logic [DW-1:0]   mem_q [DEPTH][NB];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [0:0]      state_q, state_d;
    logic [3:0]      beat_q, beat_d;
    logic            overrun_q, overrun_d;
    logic            flag_err_q, flag_err_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    assign w_flags   = {out11_ready_node3, out10_ready_node3, out11_ready_node2, out10_ready_node2,
                        out11_ready_node1, out10_ready_node1, out11_ready_node0, out10_ready_node0};
    assign w_cap     = &w_flags;
    assign w_partial = (|w_flags) && !w_cap;
    assign w_hs      = (state_q == S_STREAM) && dout_ready;
    assign w_last_hs = w_hs && (beat_q == LAST_BEAT);
    // A full FIFO still accepts when the head frame retires in the same cycle
    assign w_wr_en   = w_cap && ((count_q < FULL) || w_last_hs);
    assign w_drop    = w_cap && !w_wr_en;

    // Assemble the frame in beat order (plus optional sum beat)
    always_comb begin
        w_frame[0] = out0_node0;
        w_frame[1] = out1_node0;
        w_frame[2] = out0_node1;
        w_frame[3] = out1_node1;
        w_frame[4] = out0_node2;
        w_frame[5] = out1_node2;
        w_frame[6] = out0_node3;
        w_frame[7] = out1_node3;
`ifdef GNN_DRAIN_SUM_EN
        w_frame[8] = out0_node0 + out1_node0 + out0_node1 + out1_node1
                   + out0_node2 + out1_node2 + out0_node3 + out1_node3;
`endif
    end

    // Frame storage; contents are only visible while streaming, so no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                mem_q[wr_ptr_q][b] <= w_frame[b];
            end
        end
    end

    // FIFO bookkeeping and status next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(w_wr_en);
        rd_ptr_d = rd_ptr_q + PW'(w_last_hs);
        count_d  = count_q + CW'(w_wr_en) - CW'(w_last_hs);

        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (w_drop) begin
            overrun_d  = 1'b1;
            if (err_clr) begin
                drop_cnt_d = CNTW'(1);
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
            end
        end else if (err_clr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end

        flag_err_d = flag_err_q;
        if (w_partial) begin
            flag_err_d = 1'b1;
        end else if (err_clr) begin
            flag_err_d = 1'b0;
        end
    end

    // Stream FSM: stays in STREAM across frame boundaries while data remains
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (state_q == S_IDLE) begin
            if (count_q != '0) begin
                state_d = S_STREAM;
                beat_d  = '0;
            end
        end else if (w_hs) begin
            if (beat_q == LAST_BEAT) begin
                beat_d = '0;
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end
            end else begin
                beat_d = beat_q + 4'd1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            beat_q     <= '0;
            overrun_q  <= 1'b0;
            flag_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            beat_q     <= beat_d;
            overrun_q  <= overrun_d;
            flag_err_q <= flag_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Stream outputs are forced to zero while idle
    always_comb begin
        dout_valid = (state_q == S_STREAM);
        dout       = '0;
        dout_idx   = '0;
        dout_last  = 1'b0;
        if (dout_valid) begin
            dout      = mem_q[rd_ptr_q][beat_q[BW-1:0]];
            dout_idx  = beat_q;
            dout_last = (beat_q == LAST_BEAT);
        end
    end

    assign overrun  = overrun_q;
    assign flag_err = flag_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire
